// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for a 5-stage in-order core: RAW stall with bubble, redirect squash, post-reset fill.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned RF_BYPASS    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr_id,
  input  logic [31:0] i_instr_ex,
  input  logic [31:0] i_instr_mem,
  input  logic [31:0] i_instr_wb,
  input  logic        i_rd_wren_ex,
  input  logic        i_rd_wren_mem,
  input  logic        i_rd_wren_wb,
  input  logic        i_redirect,
  output logic        o_pc_enable,
  output logic        o_enable_if,
  output logic        o_enable_id,
  output logic        o_enable_ex,
  output logic        o_enable_mem,
  output logic        o_reset_if,
  output logic        o_reset_id,
  output logic        o_reset_ex,
  output logic        o_reset_mem,
  output logic [1:0]  o_state,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] RESET_LOAD = 4'(RESET_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam bit         WB_HAZARD  = (RF_BYPASS == 0);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;
  logic       hazard_ex, hazard_mem, hazard_wb, hazard;

  assign opcode   = i_instr_id[6:0];
  assign rs1      = i_instr_id[19:15];
  assign rs2      = i_instr_id[24:20];
  assign rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used = opcode inside {OP_RTYPE, OP_STORE, OP_BRANCH};

  // x0 is hardwired, so a source or destination of x0 never creates a dependency.
  function automatic logic producer_hit(input logic [4:0] src1, input logic use1,
                                        input logic [4:0] src2, input logic use2,
                                        input logic [31:0] instr, input logic wren);
    logic [4:0] rd;
    rd = instr[11:7];
    return wren && (rd != 5'd0) && ((use1 && (src1 == rd)) || (use2 && (src2 == rd)));
  endfunction

  assign hazard_ex  = producer_hit(rs1, rs1_used, rs2, rs2_used, i_instr_ex, i_rd_wren_ex);
  assign hazard_mem = producer_hit(rs1, rs1_used, rs2, rs2_used, i_instr_mem, i_rd_wren_mem);
  assign hazard_wb  = WB_HAZARD &&
                      producer_hit(rs1, rs1_used, rs2, rs2_used, i_instr_wb, i_rd_wren_wb);
  assign hazard     = hazard_ex || hazard_mem || hazard_wb;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_pc_enable  = 1'b1;
    o_enable_if  = 1'b1;
    o_enable_id  = 1'b1;
    o_enable_ex  = 1'b1;
    o_enable_mem = 1'b1;
    o_reset_if   = 1'b1;
    o_reset_id   = 1'b1;
    o_reset_ex   = 1'b1;
    o_reset_mem  = 1'b1;

    case (state_q)
      HOLD: begin
        o_reset_if  = 1'b0;
        o_reset_id  = 1'b0;
        o_reset_ex  = 1'b0;
        o_reset_mem = 1'b0;
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RUN, STALL: begin
        if (i_redirect) begin
          o_reset_if = 1'b0;
          o_reset_id = 1'b0;
          o_reset_ex = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = RUN;
          end
        end else if (hazard) begin
          // Hold PC and IF/ID so the consumer waits in ID; a NOP enters EX behind the producer.
          o_pc_enable = 1'b0;
          o_enable_if = 1'b0;
          o_reset_id  = 1'b0;
          state_d     = STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        o_reset_if = 1'b0;
        o_reset_id = 1'b0;
        o_reset_ex = 1'b0;
        if (i_redirect)          cnt_d   = FLUSH_LOAD;
        else if (cnt_q == 4'd0)  state_d = RUN;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = HOLD;
    endcase

    // Reset forces the fill pattern immediately and overrides any redirect or stall.
    if (i_reset) begin
      o_pc_enable  = 1'b1;
      o_enable_if  = 1'b1;
      o_enable_id  = 1'b1;
      o_enable_ex  = 1'b1;
      o_enable_mem = 1'b1;
      o_reset_if   = 1'b0;
      o_reset_id   = 1'b0;
      o_reset_ex   = 1'b0;
      o_reset_mem  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= HOLD;
      cnt_q   <= RESET_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        redirect_taken;

  assign redirect_taken = i_redirect && (state_q != HOLD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!o_pc_enable && (state_q != HOLD)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_taken)                    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

  // Immediate, funct and unrelated register fields do not influence sequencing.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{i_instr_id[31:25], i_instr_id[14:7],
                               i_instr_ex[31:12], i_instr_ex[6:0],
                               i_instr_mem[31:12], i_instr_mem[6:0],
                               i_instr_wb[31:12], i_instr_wb[6:0]};

endmodule
